mouse_pos_tracker: RTL
======================

# mouse_pos_tracker

Receives the PS/2 mouse stream, assembles 3-byte movement packets and maintains the absolute cursor position and button state consumed by the cursor/scope overlay stage. It sits between the board PS/2 pins and the VGA overlay pipeline. Its `xpos`/`ypos`/`left` outputs are the producer side of the overlay's position and select-mode inputs. Everything runs in the pixel clock domain.

## Interface
Parameters:
- `X_MAX`, default 799: largest legal xpos.
- `Y_MAX`, default 599: largest legal ypos.
- `X_RESET`, default 400: xpos after reset.
- `Y_RESET`, default 300: ypos after reset.
- `TIMEOUT_CYC`, default 40000: idle clk cycles mid-frame before the frame is aborted (1 ms at 40 MHz).

Ports:
- `clk`, in, 1: clock clk.
- `rst`, in, 1: reset rst, synchronous, active-high.
- `ps2_clk`, in, 1: asynchronous PS/2 clock from the pin.
- `ps2_data`, in, 1: asynchronous PS/2 data from the pin.
- `xpos`, out, 12: cursor x, range 0..X_MAX.
- `ypos`, out, 12: cursor y, range 0..Y_MAX, down is positive.
- `left`, out, 1: left button held.
- `right`, out, 1: right button held.
- `event`, out, 1: one-cycle pulse when a packet has been applied.

## Operation
- **Input sampling:** `ps2_clk` and `ps2_data` each pass through a 2-FF synchronizer. A falling edge on the synced clock is a sample strobe.
- **Frame FSM states:** IDLE, DATA, PARITY, STOP.
  - IDLE → DATA on a strobe with data = 0 (start bit). A strobe with data = 1 is ignored.
  - DATA shifts 8 bits LSB-first, using a 3-bit counter, then → PARITY.
  - PARITY latches the bit, then → STOP.
  - STOP: data = 1 and parity good → byte_valid. Otherwise the byte is discarded and the packet index resets to 0. Either way → IDLE.
- **Timeout:** outside IDLE, a 16-bit counter counts cycles since the last strobe. Reaching TIMEOUT_CYC → IDLE, partial byte discarded, packet index → 0.
- **Packet FSM states:** B0, B1, B2.
  - B0: the byte is accepted only if bit3 = 1 (sync). Otherwise it is dropped and the FSM stays in B0. On accept, latch status and → B1.
  - B1: latch dx, → B2.
  - B2: latch dy, assert apply, → B0.
- **Status byte bits:** bit0 left, bit1 right, bit4 X sign, bit5 Y sign, bit6 X overflow, bit7 Y overflow.
- **Apply arithmetic:**
  - dx = signed 9-bit {xsign, byte1}; dy = signed 9-bit {ysign, byte2}.
  - An overflow bit forces the corresponding delta to 0.
  - Compute in 14-bit signed: nx = xpos + dx; ny = ypos − dy (PS/2 up is positive).
  - Clamp: nx < 0 → 0, nx > X_MAX → X_MAX; same for ny with Y_MAX.
  - `left` and `right` update from the status byte in the same cycle as the position.

## Timing
- **Reset values:** xpos = X_RESET, ypos = Y_RESET, left = 0, right = 0, event = 0. Both FSMs go to IDLE/B0 and all counters clear.
- **Reset mid-frame or mid-packet:** the partial data is discarded with no output change beyond the reset values.
- **Strobe latency:** a pin falling edge produces its strobe 3 clk later (2 sync stages + edge register).
- **Apply latency:** the STOP strobe of byte 2 leads to apply in the next cycle. Outputs are registered and change 1 cycle after apply. `event` is high for exactly that one cycle, coincident with the new values.
- **Output stability:** outputs are stable between events. Malformed packets never produce an `event`.
- **Timeout boundary:** a strobe arriving on the same cycle the counter reaches TIMEOUT_CYC loses; the timeout wins.

## Configuration
- Macro: `MOUSE_POS_TRACKER_PARITY_CHECK_EN`.
- **Defined:** the byte is good only if its 8 data bits plus the parity bit contain an odd number of ones. A parity failure discards the byte and resets the packet index to 0.
- **Undefined:** the parity bit is sampled but ignored, so only the start and stop bits are checked.

## Structure
- **Shared package `mouse_pkg`:**
  - Frame-state enum and packet-state enum.
  - Status-byte bit index constants: SYNC_BIT = 3, XSIGN_BIT = 4, YSIGN_BIT = 5, XOVF_BIT = 6, YOVF_BIT = 7.
  - Default screen limits: 800×600.
- **Sub-module `ps2_byte_rx`:** synchronizer, edge detect, frame FSM and timeout. It outputs `byte_valid`, `byte_err` and an 8-bit `byte`.
- **Top level:** packet FSM and the position accumulator.

## Test plan
- **Reset:** assert rst for 2 cycles → xpos = 400, ypos = 300, left = right = 0, event = 0.
- **Basic packet:** send 0x09, 0x05, 0x03 → one event pulse; xpos = 405, ypos = 297, left = 1, right = 0.
- **Clamping:** send 0x38, 0x00, 0x00 twice → after the first, xpos = 144, ypos = 556; after the second, xpos = 0, ypos = 599.
- **Resync:** send 0x00, then 0x08, 0x01, 0x01 → the first byte is dropped; one event with xpos = 401, ypos = 299.
- **Parity fault:** send 0x08, 0x05, 0x05 with a flipped parity bit on byte 1.
  - With the macro: no event, and the next good packet decodes correctly.
  - Without the macro: event with xpos = 405, ypos = 295.
- **Timeout:** send a start bit plus 4 data bits, then hold `ps2_clk` high for 40001 cycles → frame aborted with no event. A following 0x0A, 0x00, 0x00 gives an event with right = 1 and position unchanged.

Source files
------------

// File: rtl/mouse_pkg.sv
// rtl/mouse_pkg.sv - shared types and constants for the PS/2 mouse position tracker
package mouse_pkg;

    typedef enum logic [1:0] {
        FR_IDLE,
        FR_DATA,
        FR_PARITY,
        FR_STOP
    } frame_state_t;

    typedef enum logic [1:0] {
        PKT_B0,
        PKT_B1,
        PKT_B2
    } pkt_state_t;

    // Status byte bit positions (buttons are bits 0 and 1)
    localparam int LBTN_BIT  = 0;
    localparam int RBTN_BIT  = 1;
    localparam int SYNC_BIT  = 3;
    localparam int XSIGN_BIT = 4;
    localparam int YSIGN_BIT = 5;
    localparam int XOVF_BIT  = 6;
    localparam int YOVF_BIT  = 7;

    localparam int SCREEN_W = 800;
    localparam int SCREEN_H = 600;

    typedef struct packed {
        logic yovf;
        logic xovf;
        logic ysign;
        logic xsign;
        logic rbtn;
        logic lbtn;
    } status_t;

endpackage

// File: rtl/ps2_byte_rx.sv
// rtl/ps2_byte_rx.sv - PS/2 pin synchronizer and byte framer; MOUSE_POS_TRACKER_PARITY_CHECK_EN enables odd-parity checking
module ps2_byte_rx
    import mouse_pkg::*;
#(
    parameter int TIMEOUT_CYC = 40000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       byte_valid_o,
    output logic       byte_err_o,
    output logic [7:0] byte_o
);

    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYC);

    logic clk_s1_q, clk_s2_q, clk_s3_q;
    logic data_s1_q, data_s2_q;
    logic strobe_q, sdata_q;

    frame_state_t state_q, state_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [7:0]   shift_q, shift_d;
    logic         par_q, par_d;
    logic [15:0]  tmo_q, tmo_d;
    logic         valid_q, valid_d;
    logic         err_q, err_d;
    logic         par_good;
    logic         tmo_hit;

    // Two-stage synchronizers plus edge register; idle-high reset avoids a false edge
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            clk_s3_q  <= 1'b1;
            data_s1_q <= 1'b1;
            data_s2_q <= 1'b1;
            strobe_q  <= 1'b0;
            sdata_q   <= 1'b1;
        end else begin
            clk_s1_q  <= ps2_clk_i;
            clk_s2_q  <= clk_s1_q;
            clk_s3_q  <= clk_s2_q;
            data_s1_q <= ps2_data_i;
            data_s2_q <= data_s1_q;
            strobe_q  <= clk_s3_q & ~clk_s2_q;
            sdata_q   <= data_s2_q;
        end
    end

`ifdef MOUSE_POS_TRACKER_PARITY_CHECK_EN
    assign par_good = ^{shift_q, par_q};
`else
    // Parity bit is still captured but never rejects a byte
    assign par_good = par_q | 1'b1;
`endif

    assign tmo_hit = (state_q != FR_IDLE) && (tmo_q == TMO_LIMIT);

    // Frame FSM state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FR_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tmo_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tmo_q   <= tmo_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Frame next-state: timeout beats any strobe landing in the same cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        tmo_d   = tmo_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        if (state_q == FR_IDLE || strobe_q) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 16'd1;
        end

        if (tmo_hit) begin
            state_d = FR_IDLE;
            tmo_d   = '0;
            err_d   = 1'b1;
        end else if (strobe_q) begin
            case (state_q)
                FR_IDLE: begin
                    if (!sdata_q) begin
                        state_d = FR_DATA;
                        cnt_d   = '0;
                    end
                end
                FR_DATA: begin
                    shift_d = {sdata_q, shift_q[7:1]};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = FR_PARITY;
                    end
                end
                FR_PARITY: begin
                    par_d   = sdata_q;
                    state_d = FR_STOP;
                end
                FR_STOP: begin
                    if (sdata_q && par_good) begin
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = FR_IDLE;
                end
                default: state_d = FR_IDLE;
            endcase
        end
    end

    assign byte_valid_o = valid_q;
    assign byte_err_o   = err_q;
    assign byte_o       = shift_q;

endmodule

// File: rtl/mouse_pos_tracker.sv
// rtl/mouse_pos_tracker.sv - PS/2 mouse packet decoder and clamped cursor accumulator; MOUSE_POS_TRACKER_PARITY_CHECK_EN enables parity checking
module mouse_pos_tracker
    import mouse_pkg::*;
#(
    parameter int X_MAX       = SCREEN_W - 1,
    parameter int Y_MAX       = SCREEN_H - 1,
    parameter int X_RESET     = SCREEN_W / 2,
    parameter int Y_RESET     = SCREEN_H / 2,
    parameter int TIMEOUT_CYC = 40000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        left,
    output logic        right,
    output logic        event_o
);

    localparam logic signed [13:0] X_MAX_S  = 14'(X_MAX);
    localparam logic signed [13:0] Y_MAX_S  = 14'(Y_MAX);
    localparam logic [11:0]        X_RST_12 = 12'(X_RESET);
    localparam logic [11:0]        Y_RST_12 = 12'(Y_RESET);

    logic       byte_valid;
    logic       byte_err;
    logic [7:0] rx_byte;

    pkt_state_t pkt_q, pkt_d;
    status_t    st_q, st_d;
    logic [7:0] dx_q, dx_d;
    logic       apply;

    logic [11:0] xpos_q, xpos_d, ypos_q, ypos_d;
    logic        left_q, left_d, right_q, right_d, event_q, event_d;

    logic signed [13:0] dx_s, dy_s, nx, ny;

    ps2_byte_rx #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk          (clk),
        .rst          (rst),
        .ps2_clk_i    (ps2_clk),
        .ps2_data_i   (ps2_data),
        .byte_valid_o (byte_valid),
        .byte_err_o   (byte_err),
        .byte_o       (rx_byte)
    );

    // Packet FSM state and latched status/dx
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_q <= PKT_B0;
            st_q  <= '0;
            dx_q  <= '0;
        end else begin
            pkt_q <= pkt_d;
            st_q  <= st_d;
            dx_q  <= dx_d;
        end
    end

    // Packet next-state: any bad byte resynchronises to the status byte
    always_comb begin
        pkt_d = pkt_q;
        st_d  = st_q;
        dx_d  = dx_q;
        apply = 1'b0;
        if (byte_err) begin
            pkt_d = PKT_B0;
        end else if (byte_valid) begin
            case (pkt_q)
                PKT_B0: begin
                    if (rx_byte[SYNC_BIT]) begin
                        st_d.lbtn  = rx_byte[LBTN_BIT];
                        st_d.rbtn  = rx_byte[RBTN_BIT];
                        st_d.xsign = rx_byte[XSIGN_BIT];
                        st_d.ysign = rx_byte[YSIGN_BIT];
                        st_d.xovf  = rx_byte[XOVF_BIT];
                        st_d.yovf  = rx_byte[YOVF_BIT];
                        pkt_d      = PKT_B1;
                    end
                end
                PKT_B1: begin
                    dx_d  = rx_byte;
                    pkt_d = PKT_B2;
                end
                PKT_B2: begin
                    apply = 1'b1;
                    pkt_d = PKT_B0;
                end
                default: pkt_d = PKT_B0;
            endcase
        end
    end

    // Signed accumulate with clamp; PS/2 y grows upward, screen y grows downward
    always_comb begin
        dx_s    = st_q.xovf ? 14'sd0 : {{6{st_q.xsign}}, dx_q};
        dy_s    = st_q.yovf ? 14'sd0 : {{6{st_q.ysign}}, rx_byte};
        nx      = $signed({2'b00, xpos_q}) + dx_s;
        ny      = $signed({2'b00, ypos_q}) - dy_s;
        xpos_d  = xpos_q;
        ypos_d  = ypos_q;
        left_d  = left_q;
        right_d = right_q;
        event_d = apply;
        if (apply) begin
            if (nx[13]) begin
                xpos_d = '0;
            end else if (nx > X_MAX_S) begin
                xpos_d = X_MAX_S[11:0];
            end else begin
                xpos_d = nx[11:0];
            end
            if (ny[13]) begin
                ypos_d = '0;
            end else if (ny > Y_MAX_S) begin
                ypos_d = Y_MAX_S[11:0];
            end else begin
                ypos_d = ny[11:0];
            end
            left_d  = st_q.lbtn;
            right_d = st_q.rbtn;
        end
    end

    // Registered outputs so position, buttons and event change together
    always_ff @(posedge clk) begin
        if (rst) begin
            xpos_q  <= X_RST_12;
            ypos_q  <= Y_RST_12;
            left_q  <= 1'b0;
            right_q <= 1'b0;
            event_q <= 1'b0;
        end else begin
            xpos_q  <= xpos_d;
            ypos_q  <= ypos_d;
            left_q  <= left_d;
            right_q <= right_d;
            event_q <= event_d;
        end
    end

    assign xpos    = xpos_q;
    assign ypos    = ypos_q;
    assign left    = left_q;
    assign right   = right_q;
    assign event_o = event_q;

endmodule
